// File: rtl/multicyc_mem_responder_pkg.sv
// rtl/multicyc_mem_responder_pkg.sv - shared memory-map constants for the data-bus responder
package multicyc_mem_responder_pkg;

    // Top address nibbles selecting the RAM window and the peripheral window
    localparam logic [3:0] RAM_NIBBLE    = 4'h0;
    localparam logic [3:0] PERIPH_NIBBLE = 4'h4;

    // Peripheral word offsets (iAddr[4:2])
    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_SW      = 3'd4;
    localparam logic [2:0] OFF_DIGI    = 3'd5;
    localparam logic [2:0] OFF_SYSTICK = 3'd6;

    // TCON bit positions
    localparam int TCON_RUN      = 0;
    localparam int TCON_IRQ_EN   = 1;
    localparam int TCON_IRQ_STAT = 2;

endpackage

// File: rtl/multicyc_data_ram.sv
// rtl/multicyc_data_ram.sv - word data RAM, asynchronous read, synchronous write, no reset
//
// Ports:
//   iClk     clock, write commits on posedge
//   iWe      write enable
//   iAddr    word index
//   iWrData  write data
//   oRdData  read data, combinational from iAddr
module multicyc_data_ram #(
    parameter int RAM_AW = 8
) (
    input  logic              iClk,
    input  logic              iWe,
    input  logic [RAM_AW-1:0] iAddr,
    input  logic [31:0]       iWrData,
    output logic [31:0]       oRdData
);

    logic [31:0] mem [2**RAM_AW];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[iAddr] <= iWrData;
        end
    end

    assign oRdData = mem[iAddr];

endmodule

// File: rtl/multicyc_mem_responder.sv
// rtl/multicyc_mem_responder.sv - data-bus responder: data RAM plus timer/LED/switch/7-seg/systick peripherals
//
// Ports:
//   iClk, iRst_n   clock and asynchronous active-low reset
//   iAddr          byte address (word access, bits [1:0] ignored)
//   iMemRead       read strobe, oRdData is combinational this cycle
//   iMemWrite      write strobe, committed at next posedge
//   iWrData        write data
//   oRdData        read data (0 when not reading or unmapped)
//   oIrq           timer interrupt, level
//   oLed           LED register
//   iSwitch        raw asynchronous switch inputs
//   oDigi          7-segment register {an[3:0], seg[7:0]}
import multicyc_mem_responder_pkg::*;

module multicyc_mem_responder #(
    parameter int RAM_AW = 8,
    parameter int SW_W   = 8
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic [31:0]     iAddr,
    input  logic            iMemRead,
    input  logic            iMemWrite,
    input  logic [31:0]     iWrData,
    output logic [31:0]     oRdData,
    output logic            oIrq,
    output logic [7:0]      oLed,
    input  logic [SW_W-1:0] iSwitch,
    output logic [11:0]     oDigi
);

    logic        ramSel;
    logic        periphSel;
    logic [2:0]  offset;
    logic        ramWe;
    logic [31:0] ramRdData;

    logic        periphWe;
    logic        wrTh;
    logic        wrTl;
    logic        wrTcon;
    logic        wrLed;
    logic        wrDigi;

    logic [31:0]     th;
    logic [31:0]     tl;
    logic            run;
    logic            irqEn;
    logic            irqStat;
    logic [7:0]      led;
    logic [11:0]     digi;
    logic [31:0]     sysTick;
    logic [SW_W-1:0] swSync1;
    logic [SW_W-1:0] swSync2;

    logic        tlFull;
    logic        ovfSet;

    // Byte-lane bits are irrelevant for word-only accesses
    logic unusedAddrBits;
    assign unusedAddrBits = &{1'b0, iAddr[1:0]};

    // Address decode
    always_comb begin
        ramSel    = (iAddr[31:28] == RAM_NIBBLE) && !(|iAddr[27:RAM_AW+2]);
        periphSel = (iAddr[31:28] == PERIPH_NIBBLE) && !(|iAddr[27:5]);
        offset    = iAddr[4:2];
    end

    // A write caught by reset must not land in RAM either
    assign ramWe = iMemWrite && ramSel && iRst_n;

    multicyc_data_ram #(
        .RAM_AW (RAM_AW)
    ) uDataRam (
        .iClk    (iClk),
        .iWe     (ramWe),
        .iAddr   (iAddr[RAM_AW+1:2]),
        .iWrData (iWrData),
        .oRdData (ramRdData)
    );

    // Peripheral write strobes; SWITCH, SYSTICK and reserved have none
    always_comb begin
        periphWe = iMemWrite && periphSel;
        wrTh     = periphWe && (offset == OFF_TH);
        wrTl     = periphWe && (offset == OFF_TL);
        wrTcon   = periphWe && (offset == OFF_TCON);
        wrLed    = periphWe && (offset == OFF_LED);
        wrDigi   = periphWe && (offset == OFF_DIGI);
    end

    assign tlFull = (tl == 32'hFFFF_FFFF);
    // Overflow that will latch the interrupt at this edge
    assign ovfSet = run && tlFull && irqEn;

    // Timer: core writes to TL win over count/reload; an overflow coinciding
    // with a TCON write is ORed into irq_stat so it cannot be lost.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            th      <= '0;
            tl      <= '0;
            run     <= 1'b0;
            irqEn   <= 1'b0;
            irqStat <= 1'b0;
        end else begin
            if (wrTh) begin
                th <= iWrData;
            end

            if (wrTl) begin
                tl <= iWrData;
            end else if (run) begin
                tl <= tlFull ? th : tl + 32'd1;
            end

            if (wrTcon) begin
                run     <= iWrData[TCON_RUN];
                irqEn   <= iWrData[TCON_IRQ_EN];
                irqStat <= iWrData[TCON_IRQ_STAT] | ovfSet;
            end else if (ovfSet) begin
                irqStat <= 1'b1;
            end
        end
    end

    // Simple peripherals, systick and switch synchroniser
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            led     <= '0;
            digi    <= '0;
            sysTick <= '0;
            swSync1 <= '0;
            swSync2 <= '0;
        end else begin
            if (wrLed) begin
                led <= iWrData[7:0];
            end
            if (wrDigi) begin
                digi <= iWrData[11:0];
            end
            sysTick <= sysTick + 32'd1;
            swSync1 <= iSwitch;
            swSync2 <= swSync1;
        end
    end

    // Read mux: pre-write values are returned when read and write coincide
    always_comb begin
        oRdData = 32'h0;
        if (iMemRead) begin
            if (ramSel) begin
                oRdData = ramRdData;
            end else if (periphSel) begin
                case (offset)
                    OFF_TH:      oRdData = th;
                    OFF_TL:      oRdData = tl;
                    OFF_TCON:    oRdData = {29'h0, irqStat, irqEn, run};
                    OFF_LED:     oRdData = {24'h0, led};
                    OFF_SW:      oRdData = 32'(swSync2);
                    OFF_DIGI:    oRdData = {20'h0, digi};
                    OFF_SYSTICK: oRdData = sysTick;
                    default:     oRdData = 32'h0;
                endcase
            end
        end
    end

    assign oIrq  = irqEn & irqStat;
    assign oLed  = led;
    assign oDigi = digi;

endmodule

// File: tb/tb_multicyc_mem_responder.sv
// tb/tb_multicyc_mem_responder.sv - self-checking bench for multicyc_mem_responder
`timescale 1ns/1ps

module tb_multicyc_mem_responder;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TICK = 32'h4000_0018;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic [31:0] iAddr = '0;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [31:0] iWrData = '0;
    logic [31:0] oRdData;
    logic        oIrq;
    logic [7:0]  oLed;
    logic [7:0]  iSwitch = '0;
    logic [11:0] oDigi;

    int nChecks = 0;
    int nErrors = 0;

    always #10 iClk = ~iClk;

    multicyc_mem_responder #(
        .RAM_AW (8),
        .SW_W   (8)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iAddr     (iAddr),
        .iMemRead  (iMemRead),
        .iMemWrite (iMemWrite),
        .iWrData   (iWrData),
        .oRdData   (oRdData),
        .oIrq      (oIrq),
        .oLed      (oLed),
        .iSwitch   (iSwitch),
        .oDigi     (oDigi)
    );

    // kind: 0 write, 1 read, 2 address presented with read strobe low
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #2;
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
        iAddr     = a;
        iWrData   = d;
        iMemWrite = 1'b1;
        step();
        iMemWrite = 1'b0;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        iAddr    = a;
        iMemRead = 1'b1;
        #1;
        check(name, oRdData, exp);
        iMemRead = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "ram_wr"};
        vecs[1]  = '{1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "ram_rd"};
        vecs[2]  = '{1, 32'h0000_0410, 32'h0, 32'h0, "ram_unmapped_rd"};
        vecs[3]  = '{0, 32'h0000_0014, 32'h1234_5678, 32'h0, "ram_wr2"};
        vecs[4]  = '{0, 32'h0000_0410, 32'hAAAA_5555, 32'h0, "unmapped_wr"};
        vecs[5]  = '{1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "ram_no_alias"};
        vecs[6]  = '{1, 32'h0000_0014, 32'h0, 32'h1234_5678, "ram_rd2"};
        vecs[7]  = '{2, 32'h0000_0014, 32'h0, 32'h0, "rd_strobe_low"};
        vecs[8]  = '{0, A_DIGI, 32'hFFFF_F5A5, 32'h0, "digi_wr"};
        vecs[9]  = '{1, A_DIGI, 32'h0, 32'h0000_05A5, "digi_rd"};
        vecs[10] = '{0, 32'h5000_0010, 32'h1, 32'h0, "hi_wr"};
        vecs[11] = '{1, 32'h5000_0010, 32'h0, 32'h0, "unmapped_hi"};
        vecs[12] = '{1, 32'h4000_001C, 32'h0, 32'h0, "reserved"};
        vecs[13] = '{1, 32'h4000_0020, 32'h0, 32'h0, "periph_oob"};

        // Reset state
        #3;
        check("rst_irq", {31'h0, oIrq}, 32'h0);
        check("rst_led", {24'h0, oLed}, 32'h0);
        check("rst_digi", {20'h0, oDigi}, 32'h0);
        step();
        step();
        iRst_n = 1'b1;
        peek("rst_tick", A_TICK, 32'h0);
        peek("rst_tcon", A_TCON, 32'h0);
        step();
        peek("tick_1", A_TICK, 32'h1);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            case (vecs[i].kind)
                0: doWrite(vecs[i].addr, vecs[i].data);
                1: peek(vecs[i].name, vecs[i].addr, vecs[i].exp);
                default: begin
                    iAddr    = vecs[i].addr;
                    iMemRead = 1'b0;
                    #1;
                    check(vecs[i].name, oRdData, vecs[i].exp);
                end
            endcase
        end
        check("digi_port", {20'h0, oDigi}, 32'h0000_05A5);

        // Read and write in the same cycle: old value before the edge, new after
        iAddr     = 32'h0000_0010;
        iWrData   = 32'h1111_1111;
        iMemWrite = 1'b1;
        iMemRead  = 1'b1;
        #1;
        check("rdwr_old", oRdData, 32'hDEAD_BEEF);
        step();
        iMemWrite = 1'b0;
        peek("rdwr_new", 32'h0000_0010, 32'h1111_1111);

        // Timer overflow and reload
        doWrite(A_TH, 32'hFFFF_FFFD);
        doWrite(A_TL, 32'hFFFF_FFFE);
        doWrite(A_TCON, 32'h3);
        peek("tl_start", A_TL, 32'hFFFF_FFFE);
        step();
        peek("tl_full", A_TL, 32'hFFFF_FFFF);
        check("irq_before", {31'h0, oIrq}, 32'h0);
        step();
        peek("tl_reload", A_TL, 32'hFFFF_FFFD);
        peek("tcon_stat", A_TCON, 32'h7);
        check("irq_set", {31'h0, oIrq}, 32'h1);

        // Clear with no overflow pending (TL FFFFFFFD -> FFFFFFFE at this edge)
        doWrite(A_TCON, 32'h3);
        check("irq_clear", {31'h0, oIrq}, 32'h0);
        peek("tl_after_clr", A_TL, 32'hFFFF_FFFE);
        step();
        // TL is FFFFFFFF: TCON write coincides with the overflow
        doWrite(A_TCON, 32'h3);
        check("irq_collide", {31'h0, oIrq}, 32'h1);
        peek("tl_collide", A_TL, 32'hFFFF_FFFD);

        // TL write while counting wins
        doWrite(A_TL, 32'h5);
        peek("tl_wr_wins", A_TL, 32'h5);
        step();
        peek("tl_counts", A_TL, 32'h6);

        // Peripherals
        doWrite(A_LED, 32'h0000_01A5);
        check("led_port", {24'h0, oLed}, 32'h0000_00A5);
        peek("led_rd", A_LED, 32'h0000_00A5);
        iSwitch = 8'h3C;
        step();
        peek("sw_1cyc", A_SW, 32'h0);
        step();
        peek("sw_2cyc", A_SW, 32'h0000_003C);

        // Async reset mid-count, then systick restart and SYSTICK write ignored
        #3;
        iRst_n = 1'b0;
        #1;
        check("arst_irq", {31'h0, oIrq}, 32'h0);
        check("arst_led", {24'h0, oLed}, 32'h0);
        check("arst_digi", {20'h0, oDigi}, 32'h0);
        peek("arst_tl", A_TL, 32'h0);
        peek("arst_th", A_TH, 32'h0);
        peek("arst_tick", A_TICK, 32'h0);
        peek("arst_sw", A_SW, 32'h0);
        step();
        iRst_n = 1'b1;
        peek("tick_restart", A_TICK, 32'h0);
        doWrite(A_TICK, 32'h0000_1000);
        peek("tick_wr_ign", A_TICK, 32'h1);
        step();
        peek("tick_3", A_TICK, 32'h2);
        peek("tl_stopped", A_TL, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
